// File: rtl/multi_ch_sig_det_if.sv
// -----------------------------------------------------------------------------
// multi_ch_sig_det_if
//   Bundle between the ADC capture registers / acquisition logic and the
//   multi-channel signal detector.
//
//   Handshake: SAMPLE_EN is a valid-only strobe. SAD_D is valid in every cycle
//   SAMPLE_EN is high. There is no ready; the detector accepts every strobed
//   sample. PD_VALID is also a valid-only strobe: PD carries a new sample in
//   every cycle PD_VALID is high.
//
//   master : sample source / consumer (drives SAMPLE_EN, SAD_D, thresholds)
//   slave  : detector (drives PD, PD_VALID, HAVE, HAVE_RISE, EVT_DONE, PEAK)
//   fsm_state : per-channel detector state, 2 bits per channel, debug only
// -----------------------------------------------------------------------------
interface multi_ch_sig_det_if #(
   parameter int NCH = 2,
   parameter int DW  = 14,
   parameter int CW  = 16
);
   logic                SAMPLE_EN;
   logic [NCH*DW-1:0]   SAD_D;
   logic [DW-1:0]       TH_ON;
   logic [DW-1:0]       TH_OFF;
   logic [CW-1:0]       ARM_N;
   logic [CW-1:0]       HOLD_N;
   logic [NCH*DW-1:0]   PD;
   logic                PD_VALID;
   logic [NCH-1:0]      HAVE;
   logic [NCH-1:0]      HAVE_RISE;
   logic [NCH-1:0]      EVT_DONE;
   logic [NCH*DW-1:0]   PEAK;
   logic [2*NCH-1:0]    fsm_state;

   modport master (
      output SAMPLE_EN, SAD_D, TH_ON, TH_OFF, ARM_N, HOLD_N,
      input  PD, PD_VALID, HAVE, HAVE_RISE, EVT_DONE, PEAK, fsm_state
   );

   modport slave (
      input  SAMPLE_EN, SAD_D, TH_ON, TH_OFF, ARM_N, HOLD_N,
      output PD, PD_VALID, HAVE, HAVE_RISE, EVT_DONE, PEAK, fsm_state
   );
endinterface

// File: rtl/multi_ch_sig_det.sv
// -----------------------------------------------------------------------------
// multi_ch_sig_det
//   N-channel ADC front end. Stage 1 rectifies two's-complement samples into
//   unsigned magnitudes (the most-negative code saturates). Stage 2 runs one
//   signal-presence detector per channel with arm count, hysteresis, hold-off
//   and event peak capture.
//
// Ports
//   CLK_P    : clock, all logic on the rising edge
//   RESET_N  : synchronous reset, active low
//   bus      : multi_ch_sig_det_if.slave
//              in : SAMPLE_EN, SAD_D, TH_ON, TH_OFF, ARM_N, HOLD_N
//              out: PD, PD_VALID, HAVE, HAVE_RISE, EVT_DONE, PEAK, fsm_state
//
// Latency SAD_D -> HAVE/HAVE_RISE/EVT_DONE is two cycles. Thresholds and
// count limits are sampled live each time a sample is evaluated.
// -----------------------------------------------------------------------------
module multi_ch_sig_det #(
   parameter int NCH = 2,
   parameter int DW  = 14,
   parameter int CW  = 16
) (
   input logic                 CLK_P,
   input logic                 RESET_N,
   multi_ch_sig_det_if.slave   bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ARM    = 2'd1,
      ACTIVE = 2'd2,
      HOLD   = 2'd3
   } state_t;

   localparam logic [DW-1:0] MOST_NEG = {1'b1, {(DW-1){1'b0}}};
   localparam logic [DW-1:0] MAX_POS  = {1'b0, {(DW-1){1'b1}}};
   localparam logic [DW-1:0] ONE_D    = {{(DW-1){1'b0}}, 1'b1};
   localparam logic [CW-1:0] ONE_C    = {{(CW-1){1'b0}}, 1'b1};
   localparam logic [CW:0]   ONE_X    = {{CW{1'b0}}, 1'b1};

   logic pd_valid_r;

   always_ff @(posedge CLK_P) begin
      if (!RESET_N) pd_valid_r <= 1'b0;
      else          pd_valid_r <= bus.SAMPLE_EN;
   end

   assign bus.PD_VALID = pd_valid_r;

   for (genvar k = 0; k < NCH; k++) begin : g_ch
      logic [DW-1:0] sample;
      logic [DW-1:0] mag;
      logic [DW-1:0] pd_r;
      logic [DW-1:0] peak_trk;
      logic [DW-1:0] peak_out;
      logic [DW-1:0] trk_nx;
      logic [CW-1:0] cnt;
      logic [CW:0]   cnt_nx;
      state_t        state;
      logic          have_r;
      logic          rise_r;
      logic          done_r;
      logic          on;
      logic          off;

      assign sample = bus.SAD_D[k*DW +: DW];

      // -2^(DW-1) has no positive counterpart, so it clips to full scale
      always_comb begin
         mag = sample;
         if (sample == MOST_NEG)  mag = MAX_POS;
         else if (sample[DW-1])   mag = ~sample + ONE_D;
      end

      always_ff @(posedge CLK_P) begin
         if (!RESET_N)           pd_r <= '0;
         else if (bus.SAMPLE_EN) pd_r <= mag;
      end

      assign on     = (pd_r >= bus.TH_ON);
      assign off    = (pd_r <  bus.TH_OFF);
      // one extra bit so the count compare can never wrap
      assign cnt_nx = {1'b0, cnt} + ONE_X;
      // the sample that ends an event still counts toward its peak
      assign trk_nx = (pd_r > peak_trk) ? pd_r : peak_trk;

      always_ff @(posedge CLK_P) begin
         if (!RESET_N) begin
            state    <= IDLE;
            cnt      <= '0;
            peak_trk <= '0;
            peak_out <= '0;
            have_r   <= 1'b0;
            rise_r   <= 1'b0;
            done_r   <= 1'b0;
         end else begin
            rise_r <= 1'b0;
            done_r <= 1'b0;
            if (pd_valid_r) begin
               case (state)
                  IDLE: begin
                     if (on) begin
                        peak_trk <= pd_r;
                        if (bus.ARM_N <= ONE_C) begin
                           state  <= ACTIVE;
                           have_r <= 1'b1;
                           rise_r <= 1'b1;
                           cnt    <= '0;
                        end else begin
                           state <= ARM;
                           cnt   <= ONE_C;
                        end
                     end
                  end
                  ARM: begin
                     if (!on) begin
                        state <= IDLE;
                        cnt   <= '0;
                     end else if (cnt_nx >= {1'b0, bus.ARM_N}) begin
                        state    <= ACTIVE;
                        have_r   <= 1'b1;
                        rise_r   <= 1'b1;
                        peak_trk <= pd_r;
                        cnt      <= '0;
                     end else begin
                        cnt <= cnt_nx[CW-1:0];
                     end
                  end
                  ACTIVE: begin
                     peak_trk <= trk_nx;
                     if (off) begin
                        // hold-off of 0 or 1 sample ends the event immediately
                        if (bus.HOLD_N <= ONE_C) begin
                           state    <= IDLE;
                           have_r   <= 1'b0;
                           done_r   <= 1'b1;
                           peak_out <= trk_nx;
                           cnt      <= '0;
                        end else begin
                           state <= HOLD;
                           cnt   <= ONE_C;
                        end
                     end else begin
                        cnt <= '0;
                     end
                  end
                  HOLD: begin
                     peak_trk <= trk_nx;
                     if (!off) begin
                        state <= ACTIVE;
                        cnt   <= '0;
                     end else if (cnt_nx >= {1'b0, bus.HOLD_N}) begin
                        state    <= IDLE;
                        have_r   <= 1'b0;
                        done_r   <= 1'b1;
                        peak_out <= trk_nx;
                        cnt      <= '0;
                     end else begin
                        cnt <= cnt_nx[CW-1:0];
                     end
                  end
                  default: begin
                     state  <= IDLE;
                     have_r <= 1'b0;
                     cnt    <= '0;
                  end
               endcase
            end
         end
      end

      assign bus.PD[k*DW +: DW]       = pd_r;
      assign bus.PEAK[k*DW +: DW]     = peak_out;
      assign bus.HAVE[k]              = have_r;
      assign bus.HAVE_RISE[k]         = rise_r;
      assign bus.EVT_DONE[k]          = done_r;
      assign bus.fsm_state[2*k +: 2]  = state;
   end

endmodule

// File: tb/tb_multi_ch_sig_det.sv
// -----------------------------------------------------------------------------
// tb_multi_ch_sig_det
//   Directed scenarios plus randomized traffic for multi_ch_sig_det. A
//   run-length reference model predicts all outputs once per cycle and pushes
//   the prediction into exp_q; every scenario task pops and compares inline.
// -----------------------------------------------------------------------------
module tb_multi_ch_sig_det;

   localparam int NCH  = 2;
   localparam int DW   = 14;
   localparam int CW   = 16;
   localparam int OW   = 2*NCH*DW + 1 + 3*NCH;
   localparam int MAXM = (1 << (DW-1)) - 1;

   // ---------------- clock / reset ----------------
   logic CLK_P   = 1'b0;
   logic RESET_N = 1'b0;
   always #5 CLK_P = ~CLK_P;

   multi_ch_sig_det_if #(.NCH(NCH), .DW(DW), .CW(CW)) bus ();

   multi_ch_sig_det #(.NCH(NCH), .DW(DW), .CW(CW)) dut (
      .CLK_P   (CLK_P),
      .RESET_N (RESET_N),
      .bus     (bus)
   );

   // ---------------- scoreboard ----------------
   logic [OW-1:0] exp_q[$];
   logic [OW-1:0] exp_v;
   int n_checks = 0;
   int n_fail   = 0;

   // ---------------- reference model ----------------
   logic [NCH*DW-1:0] m_pd;
   logic [NCH*DW-1:0] m_peak;
   logic              m_valid;
   logic [NCH-1:0]    m_have;
   logic [NCH-1:0]    m_rise;
   logic [NCH-1:0]    m_done;
   int                on_run  [NCH];
   int                off_run [NCH];
   logic [DW-1:0]     evt_max [NCH];

   function automatic logic [DW-1:0] rect(input logic [DW-1:0] x);
      int v;
      v = int'($signed(x));
      if (v < 0)    v = -v;
      if (v > MAXM) v = MAXM;
      return v[DW-1:0];
   endfunction

   function automatic logic [NCH*DW-1:0] pack(input logic [DW-1:0] c0, input logic [DW-1:0] c1);
      return {c1, c0};
   endfunction

   function automatic logic [OW-1:0] obs();
      return {bus.PD, bus.PD_VALID, bus.HAVE, bus.HAVE_RISE, bus.EVT_DONE, bus.PEAK};
   endfunction

   function automatic logic [OW-1:0] model_vec();
      return {m_pd, m_valid, m_have, m_rise, m_done, m_peak};
   endfunction

   // Signal is present after ARM_N consecutive on-samples and released after
   // HOLD_N consecutive off-samples; the event max is reported on release.
   task automatic model_edge();
      logic [DW-1:0] m;
      if (!RESET_N) begin
         m_pd = '0; m_peak = '0; m_valid = 1'b0;
         m_have = '0; m_rise = '0; m_done = '0;
         for (int k = 0; k < NCH; k++) begin
            on_run[k] = 0; off_run[k] = 0; evt_max[k] = '0;
         end
      end else begin
         m_rise = '0;
         m_done = '0;
         if (m_valid) begin
            for (int k = 0; k < NCH; k++) begin
               m = m_pd[k*DW +: DW];
               if (!m_have[k]) begin
                  if (m >= bus.TH_ON) begin
                     on_run[k]++;
                     if (on_run[k] >= int'(bus.ARM_N)) begin
                        m_have[k] = 1'b1; m_rise[k] = 1'b1;
                        evt_max[k] = m; on_run[k] = 0; off_run[k] = 0;
                     end
                  end else begin
                     on_run[k] = 0;
                  end
               end else begin
                  if (m > evt_max[k]) evt_max[k] = m;
                  if (m < bus.TH_OFF) begin
                     off_run[k]++;
                     if (off_run[k] >= int'(bus.HOLD_N)) begin
                        m_have[k] = 1'b0; m_done[k] = 1'b1;
                        m_peak[k*DW +: DW] = evt_max[k];
                        off_run[k] = 0; on_run[k] = 0;
                     end
                  end else begin
                     off_run[k] = 0;
                  end
               end
            end
         end
         m_valid = bus.SAMPLE_EN;
         if (bus.SAMPLE_EN)
            for (int k = 0; k < NCH; k++) m_pd[k*DW +: DW] = rect(bus.SAD_D[k*DW +: DW]);
      end
   endtask

   // ---------------- driver ----------------
   // Inputs change on the falling edge; outputs are read on the next falling edge.
   task automatic drive_cycle(input logic en, input logic [NCH*DW-1:0] d);
      bus.SAMPLE_EN = en;
      bus.SAD_D     = d;
      @(posedge CLK_P);
      model_edge();
      exp_q.push_back(model_vec());
      @(negedge CLK_P);
   endtask

   task automatic set_cfg(input logic [DW-1:0] th_on, input logic [DW-1:0] th_off,
                          input logic [CW-1:0] arm_n, input logic [CW-1:0] hold_n);
      bus.TH_ON  = th_on;
      bus.TH_OFF = th_off;
      bus.ARM_N  = arm_n;
      bus.HOLD_N = hold_n;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      logic [31:0] r;
      RESET_N = 1'b0;
      set_cfg('1, '0, 16'd3, 16'd4);
      for (int i = 0; i < 3; i++) begin
         r = $urandom;
         drive_cycle(1'b1, r[NCH*DW-1:0]);
         exp_v = exp_q.pop_front(); n_checks++;
         if (obs() !== exp_v) begin
            n_fail++; $display("FAIL reset[%0d]: dut=%h model=%h", i, obs(), exp_v);
         end
      end
      n_checks++;
      if (obs() !== '0) begin
         n_fail++; $display("FAIL reset_zero: dut=%h want 0", obs());
      end
      RESET_N = 1'b1;
   endtask

   task automatic test_rectify();
      logic [DW-1:0] c0 [4] = '{14'h3FFF, 14'h0005, 14'h1FFF, 14'h3FFB};
      logic [DW-1:0] c1 [4] = '{14'h2000, 14'h1FFF, 14'h2001, 14'h0000};
      for (int i = 0; i < 4; i++) begin
         drive_cycle(1'b1, pack(c0[i], c1[i]));
         exp_v = exp_q.pop_front(); n_checks++;
         if (obs() !== exp_v) begin
            n_fail++; $display("FAIL rectify[%0d]: dut=%h model=%h", i, obs(), exp_v);
         end
         if (i == 0) begin
            n_checks++;
            if (bus.PD !== {14'd8191, 14'd1} || bus.PD_VALID !== 1'b1) begin
               n_fail++; $display("FAIL rectify_t1: pd=%h valid=%b want %h/1", bus.PD, bus.PD_VALID, {14'd8191, 14'd1});
            end
         end
      end
      // strobe low: PD holds the last magnitude, PD_VALID drops
      drive_cycle(1'b0, pack(14'h2000, 14'h2000));
      exp_v = exp_q.pop_front(); n_checks++;
      if (obs() !== exp_v) begin
         n_fail++; $display("FAIL rectify_hold: dut=%h model=%h", obs(), exp_v);
      end
      n_checks++;
      if (bus.PD !== {14'd0, 14'd5} || bus.PD_VALID !== 1'b0) begin
         n_fail++; $display("FAIL rectify_hold_pd: pd=%h valid=%b want %h/0", bus.PD, bus.PD_VALID, {14'd0, 14'd5});
      end
   endtask

   task automatic test_arm();
      logic [DW-1:0] seq [8] = '{14'd1200, 14'd1200, 14'd900, 14'd1200,
                                 14'd1200, 14'd1200, 14'd1200, 14'd1200};
      int rise_at = -1;
      set_cfg(14'd1000, 14'd500, 16'd3, 16'd4);
      for (int i = 0; i < 8; i++) begin
         drive_cycle(1'b1, pack(seq[i], 14'd0));
         exp_v = exp_q.pop_front(); n_checks++;
         if (obs() !== exp_v) begin
            n_fail++; $display("FAIL arm[%0d]: dut=%h model=%h", i, obs(), exp_v);
         end
         if (bus.HAVE_RISE[0] && rise_at < 0) rise_at = i;
      end
      n_checks++;
      if (rise_at != 6) begin
         n_fail++; $display("FAIL arm_rise_cycle: got %0d want 6", rise_at);
      end
   endtask

   task automatic test_hold();
      logic [DW-1:0] seq [10] = '{14'd400, 14'd400, 14'd400, 14'd600, 14'd400,
                                  14'd400, 14'd400, 14'd400, 14'd0, 14'd0};
      int done_at = -1;
      for (int i = 0; i < 10; i++) begin
         drive_cycle(1'b1, pack(seq[i], 14'd0));
         exp_v = exp_q.pop_front(); n_checks++;
         if (obs() !== exp_v) begin
            n_fail++; $display("FAIL hold[%0d]: dut=%h model=%h", i, obs(), exp_v);
         end
         if (bus.EVT_DONE[0] && done_at < 0) done_at = i;
      end
      n_checks++;
      if (done_at != 8 || bus.PEAK[DW-1:0] !== 14'd1200) begin
         n_fail++; $display("FAIL hold_done: cycle=%0d peak=%0d want 8/1200", done_at, bus.PEAK[DW-1:0]);
      end
   endtask

   task automatic test_peak();
      logic [DW-1:0] e1 [8] = '{14'd700, 14'd3000, 14'd1500, 14'd100,
                                14'd100, 14'd100, 14'd100, 14'd0};
      logic [DW-1:0] e2 [8] = '{14'd800, 14'd900, 14'd100, 14'd100,
                                14'd100, 14'd100, 14'd0, 14'd0};
      int  done_at = -1;
      logic held_ok = 1'b1;
      set_cfg(14'd600, 14'd500, 16'd1, 16'd4);
      for (int i = 0; i < 8; i++) begin
         drive_cycle(1'b1, pack(e1[i], 14'd0));
         exp_v = exp_q.pop_front(); n_checks++;
         if (obs() !== exp_v) begin
            n_fail++; $display("FAIL peak_e1[%0d]: dut=%h model=%h", i, obs(), exp_v);
         end
         if (bus.EVT_DONE[0] && done_at < 0) done_at = i;
      end
      n_checks++;
      if (done_at != 7 || bus.PEAK[DW-1:0] !== 14'd3000) begin
         n_fail++; $display("FAIL peak_e1_done: cycle=%0d peak=%0d want 7/3000", done_at, bus.PEAK[DW-1:0]);
      end
      for (int i = 0; i < 8; i++) begin
         drive_cycle(1'b1, pack(e2[i], 14'd0));
         exp_v = exp_q.pop_front(); n_checks++;
         if (obs() !== exp_v) begin
            n_fail++; $display("FAIL peak_e2[%0d]: dut=%h model=%h", i, obs(), exp_v);
         end
         if (i < 6 && bus.PEAK[DW-1:0] !== 14'd3000) held_ok = 1'b0;
      end
      n_checks++;
      if (!held_ok || bus.PEAK[DW-1:0] !== 14'd900) begin
         n_fail++; $display("FAIL peak_e2_done: held=%b peak=%0d want 1/900", held_ok, bus.PEAK[DW-1:0]);
      end
   endtask

   task automatic test_strobe();
      logic          en_t [16] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1,
                                   1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      logic [DW-1:0] v_t  [16] = '{14'd1200, 14'd0, 14'd1200, 14'd0, 14'd0, 14'd1200, 14'd1200, 14'd100,
                                   14'd3000, 14'd100, 14'd3000, 14'd3000, 14'd100, 14'd0, 14'd0, 14'd0};
      int rises = 0;
      int dones = 0;
      set_cfg(14'd1000, 14'd500, 16'd3, 16'd3);
      for (int i = 0; i < 16; i++) begin
         drive_cycle(en_t[i], pack(v_t[i], v_t[i]));
         exp_v = exp_q.pop_front(); n_checks++;
         if (obs() !== exp_v) begin
            n_fail++; $display("FAIL strobe[%0d]: dut=%h model=%h", i, obs(), exp_v);
         end
         if (bus.HAVE_RISE[0]) rises++;
         if (bus.EVT_DONE[0])  dones++;
      end
      n_checks++;
      if (rises != 1 || dones != 1) begin
         n_fail++; $display("FAIL strobe_pulses: rise=%0d done=%0d want 1/1", rises, dones);
      end
   endtask

   task automatic test_reset_mid();
      int dones = 0;
      set_cfg(14'd1000, 14'd500, 16'd1, 16'd4);
      for (int i = 0; i < 3; i++) begin
         drive_cycle(1'b1, pack(14'd2000, 14'd2000));
         exp_v = exp_q.pop_front(); n_checks++;
         if (obs() !== exp_v) begin
            n_fail++; $display("FAIL rstmid_pre[%0d]: dut=%h model=%h", i, obs(), exp_v);
         end
      end
      n_checks++;
      if (bus.HAVE !== 2'b11) begin
         n_fail++; $display("FAIL rstmid_have: got %b want 11", bus.HAVE);
      end
      RESET_N = 1'b0;
      drive_cycle(1'b1, pack(14'd2000, 14'd2000));
      exp_v = exp_q.pop_front(); n_checks++;
      if (obs() !== exp_v) begin
         n_fail++; $display("FAIL rstmid_rst: dut=%h model=%h", obs(), exp_v);
      end
      n_checks++;
      if (obs() !== '0) begin
         n_fail++; $display("FAIL rstmid_zero: dut=%h want 0", obs());
      end
      RESET_N = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drive_cycle(1'b1, pack(14'd0, 14'd0));
         exp_v = exp_q.pop_front(); n_checks++;
         if (obs() !== exp_v) begin
            n_fail++; $display("FAIL rstmid_post[%0d]: dut=%h model=%h", i, obs(), exp_v);
         end
         if (bus.EVT_DONE !== 2'b00) dones++;
      end
      n_checks++;
      if (dones != 0) begin
         n_fail++; $display("FAIL rstmid_no_done: got %0d pulses want 0", dones);
      end
   endtask

   task automatic test_random();
      int th_on, th_off, arm, hold, mag;
      logic [DW-1:0] s [NCH];
      logic en;
      for (int i = 0; i < 600; i++) begin
         if (i % 50 == 0) begin
            th_on  = $urandom_range(200, 3000);
            th_off = $urandom_range(100, 3200);
            arm    = $urandom_range(0, 4);
            hold   = $urandom_range(2, 5);
            set_cfg(th_on[DW-1:0], th_off[DW-1:0], arm[CW-1:0], hold[CW-1:0]);
         end
         RESET_N = ($urandom_range(0, 199) != 0);
         en = ($urandom_range(0, 3) != 0);
         for (int k = 0; k < NCH; k++) begin
            mag  = $urandom_range(0, 3500);
            s[k] = mag[DW-1:0];
            if ($urandom_range(0, 1) == 1) s[k] = ~s[k] + 14'd1;
            if ($urandom_range(0, 40) == 0) s[k] = 14'h2000;
         end
         drive_cycle(en, pack(s[0], s[1]));
         exp_v = exp_q.pop_front(); n_checks++;
         if (obs() !== exp_v) begin
            n_fail++; $display("FAIL random[%0d]: dut=%h model=%h", i, obs(), exp_v);
         end
      end
      RESET_N = 1'b1;
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      bus.SAMPLE_EN = 1'b0;
      bus.SAD_D     = '0;
      set_cfg('1, '0, 16'd3, 16'd4);
      @(negedge CLK_P);
      test_reset();
      test_rectify();
      test_arm();
      test_hold();
      test_peak();
      test_strobe();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
